// File: rtl/result_monitor_pkg.sv
// Shared types and the masked-compare helper for the result monitor.
package result_monitor_pkg;

  localparam int MAX_DW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CH_PEND  = 2'd0,
    CH_MATCH = 2'd1,
    CH_MISS  = 2'd2
  } chan_st_e;

  // Callers zero-extend bus-width values to MAX_DW.
  function automatic chan_st_e chan_compare(input logic [MAX_DW-1:0] data,
                                            input logic [MAX_DW-1:0] expv,
                                            input logic [MAX_DW-1:0] mask);
    return (((data ^ expv) & mask) == '0) ? CH_MATCH : CH_MISS;
  endfunction

endpackage

// File: rtl/result_monitor_chan.sv
// One watched address: config registers, capture status and hit flag.
module result_monitor_chan
  import result_monitor_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_cfg_we,
  input  logic          i_cfg_en,
  input  logic [AW-1:0] i_cfg_addr,
  input  logic [DW-1:0] i_cfg_exp,
  input  logic [DW-1:0] i_cfg_mask,
  input  logic          i_clear,
  input  logic          i_arm,
  input  logic          i_bus_we,
  input  logic [AW-1:0] i_bus_addr,
  input  logic [DW-1:0] i_bus_wdata,
  output logic          o_en,
  output logic          o_hit,
  output logic          o_ok_nxt
);

  logic              r_en;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_exp;
  logic [DW-1:0]     r_mask;
  chan_st_e          r_st;
  chan_st_e          w_st_nxt;
  logic              r_hit;
  logic              w_capture;
  logic [MAX_DW-1:0] w_data_x;
  logic [MAX_DW-1:0] w_exp_x;
  logic [MAX_DW-1:0] w_mask_x;

  always_comb begin
    w_data_x           = '0;
    w_exp_x            = '0;
    w_mask_x           = '0;
    w_data_x[DW-1:0]   = i_bus_wdata;
    w_exp_x[DW-1:0]    = r_exp;
    w_mask_x[DW-1:0]   = r_mask;
  end

  assign w_capture = i_arm & i_bus_we & r_en & (i_bus_addr == r_addr);

  // Next status is exported so the top can judge the final window cycle.
  always_comb begin
    w_st_nxt = r_st;
    if (i_clear)
      w_st_nxt = CH_PEND;
    else if (w_capture)
      w_st_nxt = chan_compare(w_data_x, w_exp_x, w_mask_x);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_exp  <= '0;
      r_mask <= '0;
    end else if (i_cfg_we) begin
      r_en   <= i_cfg_en;
      r_addr <= i_cfg_addr;
      r_exp  <= i_cfg_exp;
      r_mask <= i_cfg_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st  <= CH_PEND;
      r_hit <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      if (i_clear)
        r_hit <= 1'b0;
      else if (w_capture)
        r_hit <= 1'b1;
    end
  end

  assign o_en     = r_en;
  assign o_hit    = r_hit;
  assign o_ok_nxt = (w_st_nxt == CH_MATCH);

endmodule

// File: rtl/result_monitor.sv
// Multi-channel bus-write result checker: window FSM, cycle counter, pass reduction.
module result_monitor
  import result_monitor_pkg::*;
#(
  parameter  int NCHAN = 4,
  parameter  int AW    = 16,
  parameter  int DW    = 8,
  parameter  int CW    = 16,
  localparam int SELW  = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             ph1,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [SELW-1:0]  cfg_sel,
  input  logic             cfg_en,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [DW-1:0]    cfg_exp,
  input  logic [DW-1:0]    cfg_mask,
  input  logic [CW-1:0]    limit,
  input  logic             start,
  input  logic             bus_we,
  input  logic [AW-1:0]    bus_addr,
  input  logic [DW-1:0]    bus_wdata,
  output logic             armed,
  output logic             done,
  output logic             pass,
  output logic [NCHAN-1:0] hit_vec,
  output logic [NCHAN-1:0] fail_vec,
  output logic [CW-1:0]    cycles
);

  state_e           r_state;
  logic             r_armed;
  logic             r_done;
  logic             r_pass;
  logic [NCHAN-1:0] r_fail;
  logic [CW-1:0]    r_cycles;
  logic [CW-1:0]    r_limit;

  logic             w_arm;
  logic             w_start;
  logic             w_last;
  logic [NCHAN-1:0] w_en;
  logic [NCHAN-1:0] w_hit;
  logic [NCHAN-1:0] w_ok_nxt;
  logic [NCHAN-1:0] w_cfg_we;
  logic [NCHAN-1:0] w_fail_nxt;

  assign w_arm      = (r_state == S_ARMED);
  assign w_start    = start & ~w_arm;
  assign w_last     = w_arm & (r_cycles == r_limit);
  assign w_fail_nxt = w_en & ~w_ok_nxt;

  for (genvar g = 0; g < NCHAN; g++) begin : g_chan
    // Out-of-range selects simply decode to no channel.
    assign w_cfg_we[g] = cfg_we & ~w_arm & (cfg_sel == SELW'(g));

    result_monitor_chan #(
      .AW(AW),
      .DW(DW)
    ) u_chan (
      .clk        (ph1),
      .rst_n      (reset),
      .i_cfg_we   (w_cfg_we[g]),
      .i_cfg_en   (cfg_en),
      .i_cfg_addr (cfg_addr),
      .i_cfg_exp  (cfg_exp),
      .i_cfg_mask (cfg_mask),
      .i_clear    (w_start),
      .i_arm      (w_arm),
      .i_bus_we   (bus_we),
      .i_bus_addr (bus_addr),
      .i_bus_wdata(bus_wdata),
      .o_en       (w_en[g]),
      .o_hit      (w_hit[g]),
      .o_ok_nxt   (w_ok_nxt[g])
    );
  end

  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_armed  <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_fail   <= '0;
      r_cycles <= '0;
      r_limit  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state  <= S_ARMED;
            r_armed  <= 1'b1;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= '0;
            r_cycles <= '0;
            r_limit  <= limit;
          end
        end
        S_ARMED: begin
          // The final cycle's write is folded in through the channels' next status.
          if (w_last) begin
            r_state <= S_DONE;
            r_armed <= 1'b0;
            r_done  <= 1'b1;
            r_fail  <= w_fail_nxt;
            r_pass  <= (|w_en) & ~(|w_fail_nxt);
          end else if (r_cycles != {CW{1'b1}}) begin
            r_cycles <= r_cycles + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_armed <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign armed    = r_armed;
  assign done     = r_done;
  assign pass     = r_pass;
  assign hit_vec  = w_hit;
  assign fail_vec = r_fail;
  assign cycles   = r_cycles;

endmodule

// File: doc/result_monitor.md
# result_monitor

Synthesizable multi-channel result checker for the processor regression suites. It snoops CPU data-bus writes to up to NCHAN configured RAM addresses and compares each captured value against a masked expected value. Over a bounded cycle window it reports per-channel hit/fail status and an overall pass. It sits beside `top.mem` on the CPU write bus, so a single directed ROM can self-check several result bytes on silicon or FPGA, with no testbench peeking into memory.

## Interface
Parameters:
- NCHAN, 4: number of checked addresses (1..16)
- AW, 16: bus address width
- DW, 8: bus data width
- CW, 16: cycle-window counter width

Ports:
- ph1  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all state
- cfg_we  in  1  configuration write strobe
- cfg_sel  in  $clog2(NCHAN) (min 1)  channel being configured
- cfg_en  in  1  channel enable
- cfg_addr  in  AW  address to watch
- cfg_exp  in  DW  expected value
- cfg_mask  in  DW  compare mask (1 = bit checked)
- limit  in  CW  window length in cycles, sampled on start
- start  in  1  arm the monitor (single-cycle pulse)
- bus_we  in  1  CPU write strobe
- bus_addr  in  AW  CPU address
- bus_wdata  in  DW  CPU write data
- armed  out  1  window open
- done  out  1  window closed, results valid
- pass  out  1  valid only with done
- hit_vec  out  NCHAN  channel saw at least one write
- fail_vec  out  NCHAN  channel enabled and not matching at done
- cycles  out  CW  cycles elapsed in the current/last window

## Operation
- States: IDLE -> ARMED on start. ARMED -> DONE when the counter equals the latched limit. DONE -> ARMED on start. No other transitions.
- Reset value of every output is 0. The FSM resets to IDLE. All channel configs reset to disabled, addr/exp/mask 0.
- Config writes are accepted in IDLE and DONE only and are ignored while ARMED. A cfg_sel value >= NCHAN is ignored.
- Start in IDLE or DONE does the following:
  - clears every channel status to PEND, hit_vec and cycles;
  - latches limit;
  - deasserts done/pass.
- Start while ARMED is ignored.
- Per channel, the status takes one of PEND, MATCH or MISS.
- In ARMED, when bus_we=1 and bus_addr equals the channel address of an enabled channel:
  - the channel's hit bit sets;
  - status becomes MATCH if ((bus_wdata ^ exp) & mask) == 0, else MISS.
- Last write wins: a later write to the same address overwrites the status, so intermediate values are harmless.
- Several channels may watch the same address; all of them update together.
- Writes in IDLE/DONE have no effect.
- At DONE:
  - fail_vec[i] = en[i] & (status[i] != MATCH), so an enabled channel that was never written fails;
  - pass = (at least one channel enabled) & (fail_vec == 0). With no channel enabled, pass is 0.
- cycles saturates at all-ones and holds its value in DONE.

## Timing
- All inputs are sampled on the rising edge of ph1. Outputs are registered.
- Status, hit_vec and fail_vec update one cycle after the sampled bus write.
- Start is sampled at edge 0. armed=1 and cycles=0 after edge 0, and cycles increments on each later edge.
- With limit=L, the window covers L+1 sampled cycles (counter values 0..L).
- A write sampled in the same cycle as the counter reaching L is captured.
- done=1 and armed=0 after the following edge. done, pass and vectors then hold stable until the next start.
- limit=0: exactly one sampled cycle, then done.
- Reset may assert at any time, including mid-window. Outputs go to 0 asynchronously and nothing is reported.

## Structure
- result_monitor_pkg holds:
  - the state enum (S_IDLE, S_ARMED, S_DONE);
  - the channel status enum (CH_PEND, CH_MATCH, CH_MISS);
  - the shared match function.
- The sub-module result_monitor_chan is instantiated NCHAN times. Each instance holds the config registers, status and hit bit, and is driven by arm/clear and the bus signals.
- The top level contains the FSM, the counter and the pass reduction.

## Test plan
- Ch0 configured with addr 0x0071, exp 0xFF, mask 0xFF, en=1; limit=100; start; write 0xFF to 0x0071 at cycle 10 -> done at cycle 101, pass=1, hit_vec=0001, fail_vec=0000.
- Same setup, with writes of 0xFE then 0xFF to 0x0071 -> pass=1. Reverse order (0xFF then 0xFE) -> pass=0, fail_vec=0001.
- Ch1 configured with addr 0x0200, exp 0x80, mask 0xF0, en=1; write 0x8F -> MATCH. Also enable ch2 but never write its address -> fail_vec=0100, pass=0.
- limit=0 with a write to a watched address in the start+1 cycle -> done one cycle later. Then a write after done -> no status change.
- cfg_we during ARMED changing ch0 exp -> ignored; the original exp is still used. Assert reset mid-window -> all outputs 0 and state IDLE; a fresh start works normally.
- No channels enabled; start with limit=5 -> done with pass=0, fail_vec=0, cycles=5.
